draw_rect_engine: RTL and testbench
===================================

// Module: draw_rect_engine
// PURPOSE
//  Parametrised rectangle rasteriser feeding the VGA adapter plot port. Latches origin, size,
//  colour and erase on start; emits one pixel per clk in raster order (x inner, y outer);
//  pulses done when finished. Replaces fixed 4x4 square drawing for notes, bars and erase.
// PARAMETERS
//  X_W       8    x coordinate width (bits)
//  Y_W       7    y coordinate width (bits)
//  SIZE_W    4    width of rect_w/rect_h; max rectangle 2^SIZE_W-1 per side
//  COLOUR_W  3    colour width
//  SCREEN_W  160  visible columns (used only when clipping compiled in)
//  SCREEN_H  120  visible rows (used only when clipping compiled in)
// PORTS
//  clk         in   1         system clock (CLOCK_50)
//  resetn      in   1         synchronous, active-low reset
//  start       in   1         request; sampled only in IDLE
//  x0          in   X_W       origin x (top-left)
//  y0          in   Y_W       origin y (top-left)
//  rect_w      in   SIZE_W    width in pixels
//  rect_h      in   SIZE_W    height in pixels
//  colour_in   in   COLOUR_W  fill colour
//  erase       in   1         1: fill with 0 (black) regardless of colour_in
//  busy        out  1         high in DRAW
//  done        out  1         one-cycle pulse in DONE
//  x_out       out  X_W       pixel x, valid when plot=1
//  y_out       out  Y_W       pixel y, valid when plot=1
//  colour_out  out  COLOUR_W  pixel colour
//  plot        out  1         VGA write enable
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE; busy, done, plot, x_out, y_out, colour_out = 0.
//  - States: IDLE, DRAW, DONE. IDLE -start-> DRAW (or DONE if rect_w==0 or rect_h==0);
//    DRAW -last pixel-> DONE; DONE -> IDLE unconditionally (one cycle).
//  - On accepted start (edge N): latch x0, y0, rect_w, rect_h, colour (0 if erase); clear offset
//    counters xo, yo. First pixel is presented in cycle N+1 with plot=1.
//  - DRAW pixel: x_out = x0_l + xo, y_out = y0_l + yo, truncated to X_W / Y_W bits (mod 2^n wrap).
//    Per cycle: xo++; when xo == w-1, xo <= 0 and yo++. Last pixel: xo==w-1 and yo==h-1.
//  - Exactly w*h DRAW cycles; done high in cycle N+1+w*h; busy low in that cycle; new start
//    accepted from the following IDLE cycle (cycle N+2+w*h).
//  - Zero size: start -> DONE next cycle, no plot, done pulses at N+1.
//  - start while in DRAW or DONE: ignored, no queueing; latched values unaffected by input changes.
//  - Reset mid-operation: next edge -> IDLE, all outputs 0, no done pulse.
//  - colour_out = latched colour in DRAW, 0 otherwise.
// CONFIGURATION
//  - DRAW_RECT_CLIP_EN defined: sum x0_l+xo computed at X_W+1 bits (y likewise); pixels with
//    x >= SCREEN_W or y >= SCREEN_H get plot=0, still occupy their cycle (timing unchanged, done
//    timing identical).
//  - Not defined: no bounds check; plot=1 every DRAW cycle; coordinates wrap modulo 2^X_W / 2^Y_W.
// TESTING
//  1. x0=10,y0=20,w=4,h=4,colour=5,start 1 cycle -> 16 plots (10,20),(11,20)..(13,23), colour 5,
//     done at cycle 17 after start edge, busy high cycles 1-16.
//  2. Same with erase=1, colour_in=7 -> 16 plots, colour_out=0 each.
//  3. w=0,h=5 -> no plot, done one cycle after start; w=1,h=1 -> single plot, done next cycle.
//  4. start held high through a 2x3 draw with changing x0 -> exactly 6 plots from original x0; next
//     draw begins only after DONE->IDLE.
//  5. resetn low at pixel 5 of a 4x4 -> plot, busy low next cycle, done never asserted.
//  6. x0=158,y0=118,w=4,h=4: with DRAW_RECT_CLIP_EN -> plot only for x in {158,159}, y in
//     {118,119} (4 pixels), done still at cycle 17; without -> 16 plots incl. x=160,161.

Source files
------------

// File: rtl/draw_rect_engine.sv
`default_nettype none
// ============================================================================
//  Module   : draw_rect_engine
//  Purpose  : Rectangle rasteriser for the VGA adapter plot port. It latches
//             the origin, size, colour and erase flag on start. It then emits
//             one pixel per clock in raster order (x inner, y outer) and
//             pulses done when the rectangle is finished.
//  Ports    : clk, resetn (synchronous, active-low)
//             start, x0, y0, rect_w, rect_h, colour_in, erase  -> request
//             busy, done                                       -> status
//             x_out, y_out, colour_out, plot                   -> plot port
//  Options  : DRAW_RECT_CLIP_EN - when defined, pixels outside
//             SCREEN_W x SCREEN_H are suppressed (plot=0). They still take
//             their cycle, so the timing does not change.
//  Revision : 1.0 - initial release
// ============================================================================
module draw_rect_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SIZE_W   = 4,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [SIZE_W-1:0]   rect_w,
    input  logic [SIZE_W-1:0]   rect_h,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                erase,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot
);

    // Reject configurations where the offset does not fit the coordinate
    // width, or the screen does not fit the coordinate range.
    generate
        if (SIZE_W > X_W || SIZE_W > Y_W ||
            SCREEN_W > (1 << X_W) || SCREEN_H > (1 << Y_W)) begin : g_bad_cfg
            $error("draw_rect_engine: inconsistent parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic [SIZE_W-1:0]   r_w;
    logic [SIZE_W-1:0]   r_h;
    logic [COLOUR_W-1:0] r_colour;
    logic [SIZE_W-1:0]   r_xo;
    logic [SIZE_W-1:0]   r_yo;
    logic [SIZE_W-1:0]   w_xo_next;
    logic [SIZE_W-1:0]   w_yo_next;

    logic                w_start_ok;
    logic                w_zero_size;
    logic                w_row_end;
    logic                w_last;
    logic [X_W-1:0]      w_x_base;
    logic [Y_W-1:0]      w_y_base;
    logic [COLOUR_W-1:0] w_colour_base;
    logic [X_W-1:0]      w_x_pix;
    logic [Y_W-1:0]      w_y_pix;
    logic                w_in_bounds;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_zero_size = (rect_w == '0) || (rect_h == '0);
    assign w_row_end   = (r_xo == r_w - SIZE_W'(1));
    assign w_last      = w_row_end && (r_yo == r_h - SIZE_W'(1));

    // The outputs are registered, so the first pixel is computed on the
    // accepting edge. On that edge the latches are not yet loaded, and the
    // base values must come straight from the inputs.
    assign w_x_base      = (r_state == S_IDLE) ? x0 : r_x0;
    assign w_y_base      = (r_state == S_IDLE) ? y0 : r_y0;
    assign w_colour_base = (r_state == S_IDLE) ? (erase ? '0 : colour_in) : r_colour;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_xo_next    = r_xo;
        w_yo_next    = r_yo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_xo_next    = '0;
                    w_yo_next    = '0;
                    w_state_next = w_zero_size ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else if (w_row_end) begin
                    w_xo_next = '0;
                    w_yo_next = r_yo + SIZE_W'(1);
                end else begin
                    w_xo_next = r_xo + SIZE_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef DRAW_RECT_CLIP_EN
    // The sum is one bit wider than the coordinate, so a carry out of the
    // coordinate range still counts as off-screen.
    localparam logic [X_W:0] c_screen_w = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] c_screen_h = (Y_W+1)'(SCREEN_H);
    logic [X_W:0] w_x_sum;
    logic [Y_W:0] w_y_sum;
    assign w_x_sum     = {1'b0, w_x_base} + (X_W+1)'(w_xo_next);
    assign w_y_sum     = {1'b0, w_y_base} + (Y_W+1)'(w_yo_next);
    assign w_x_pix     = w_x_sum[X_W-1:0];
    assign w_y_pix     = w_y_sum[Y_W-1:0];
    assign w_in_bounds = (w_x_sum < c_screen_w) && (w_y_sum < c_screen_h);
`else
    assign w_x_pix     = w_x_base + X_W'(w_xo_next);
    assign w_y_pix     = w_y_base + Y_W'(w_yo_next);
    assign w_in_bounds = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_colour   <= '0;
            r_xo       <= '0;
            r_yo       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            if (w_start_ok) begin
                r_x0     <= x0;
                r_y0     <= y0;
                r_w      <= rect_w;
                r_h      <= rect_h;
                r_colour <= erase ? '0 : colour_in;
            end
            r_xo       <= w_xo_next;
            r_yo       <= w_yo_next;
            busy       <= (w_state_next == S_DRAW);
            done       <= (w_state_next == S_DONE);
            plot       <= (w_state_next == S_DRAW) && w_in_bounds;
            x_out      <= w_x_pix;
            y_out      <= w_y_pix;
            colour_out <= (w_state_next == S_DRAW) ? w_colour_base : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_rect_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_rect_engine
//  Purpose  : Directed self-checking bench for draw_rect_engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_draw_rect_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [3:0] rect_w;
    logic [3:0] rect_h;
    logic [2:0] colour_in;
    logic       erase;
    logic       busy;
    logic       done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;

    int n_assert = 0;
    int n_fail   = 0;

    draw_rect_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .rect_w     (rect_w),
        .rect_h     (rect_h),
        .colour_in  (colour_in),
        .erase      (erase),
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse and check every pixel, then done and the
    // return to idle.
    task automatic run_rect(input string tag, input int xs, input int ys, input int w,
                            input int h, input int col, input bit er);
        int ex;
        int ey;
        bit vis;
        x0 = 8'(xs); y0 = 7'(ys); rect_w = 4'(w); rect_h = 4'(h);
        colour_in = 3'(col); erase = er; start = 1'b1;
        step();
        start = 1'b0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                ex = (xs + xx) % 256;
                ey = (ys + yy) % 128;
`ifdef DRAW_RECT_CLIP_EN
                vis = ((xs + xx) < 160) && ((ys + yy) < 120);
`else
                vis = 1'b1;
`endif
                chk({tag, "_plot"}, 32'(plot), 32'(vis));
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_done_low"}, 32'(done), 32'd0);
                chk({tag, "_x"}, 32'(x_out), 32'(ex));
                chk({tag, "_y"}, 32'(y_out), 32'(ey));
                chk({tag, "_colour"}, 32'(colour_out), er ? 32'd0 : 32'(col));
                step();
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_plot_end"}, 32'(plot), 32'd0);
        chk({tag, "_colour_end"}, 32'(colour_out), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit seen_done;
        resetn = 1'b0; start = 1'b0; x0 = '0; y0 = '0;
        rect_w = '0; rect_h = '0; colour_in = '0; erase = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_colour", 32'(colour_out), 32'd0);
        resetn = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Basic 4x4 fill, then the same rectangle erased.
        run_rect("t1", 10, 20, 4, 4, 5, 1'b0);
        run_rect("t2", 10, 20, 4, 4, 7, 1'b1);

        // Zero width: done comes on the next cycle with no plot.
        x0 = 8'd3; y0 = 7'd3; rect_w = 4'd0; rect_h = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("t3z_done", 32'(done), 32'd1);
        chk("t3z_plot", 32'(plot), 32'd0);
        chk("t3z_busy", 32'(busy), 32'd0);
        step();
        chk("t3z_done_pulse", 32'(done), 32'd0);
        chk("t3z_plot2", 32'(plot), 32'd0);
        run_rect("t3one", 77, 33, 1, 1, 2, 1'b0);

        // start held high; x0 changes while drawing.
        x0 = 8'd30; y0 = 7'd40; rect_w = 4'd2; rect_h = 4'd3; colour_in = 3'd6;
        erase = 1'b0; start = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            x0 = 8'(50 + k);
            chk("t4_plot", 32'(plot), 32'd1);
            chk("t4_x", 32'(x_out), 32'(30 + (k % 2)));
            chk("t4_y", 32'(y_out), 32'(40 + (k / 2)));
            step();
        end
        x0 = 8'd50;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_plot_done", 32'(plot), 32'd0);
        step();
        chk("t4_idle_plot", 32'(plot), 32'd0);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_done", 32'(done), 32'd0);
        step();
        start = 1'b0;
        chk("t4_new_plot", 32'(plot), 32'd1);
        chk("t4_new_x", 32'(x_out), 32'd50);
        seen_done = 1'b0;
        for (int k = 0; k < 20 && !seen_done; k++) begin
            step();
            seen_done = done;
        end
        chk("t4_new_done_seen", 32'(seen_done), 32'd1);
        step();

        // Reset while the fifth pixel is shown.
        x0 = 8'd0; y0 = 7'd0; rect_w = 4'd4; rect_h = 4'd4; colour_in = 3'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_plot", 32'(plot), 32'd1);
            chk("t5_x", 32'(x_out), 32'(k % 4));
            if (k < 4) step();
        end
        resetn = 1'b0;
        step();
        chk("t5_rst_plot", 32'(plot), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_colour", 32'(colour_out), 32'd0);
        resetn = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen_done = seen_done | done | plot;
        end
        chk("t5_no_done_after_rst", 32'(seen_done), 32'd0);

        // Near the screen corner: clipped or wrapped depending on the build.
        run_rect("t6", 158, 118, 4, 4, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
